// File: rtl/wm_cycle_controller.sv
// wm_cycle_controller: washing-machine sequencer (soap wash, NUM_RINSE rinses, spin) with fill/drain watchdogs.
// Optional macro WM_PAUSE_EN: pause in WASH/SPIN stops the motor and freezes the timer.
module wm_cycle_controller #(
  parameter int NUM_RINSE   = 1,
  parameter int TIMER_W     = 16,
  parameter int WASH_TICKS  = 1000,
  parameter int SPIN_TICKS  = 500,
  parameter int FILL_LIMIT  = 2000,
  parameter int DRAIN_LIMIT = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       door_close,
  input  logic       filled,
  input  logic       detergent_added,
  input  logic       drained,
  input  logic       pause,
  output logic       door_lock,
  output logic       motor_on,
  output logic       fill_valve_on,
  output logic       drain_valve_on,
  output logic       soap_wash,
  output logic       water_wash,
  output logic       done,
  output logic       fault,
  output logic [3:0] rinse_count,
  output logic [2:0] state
);
  localparam logic [2:0] S_IDLE = 3'd0, S_FILL = 3'd1, S_DET = 3'd2, S_WASH = 3'd3,
                         S_DRAIN = 3'd4, S_SPIN = 3'd5, S_DONE = 3'd6, S_FAULT = 3'd7;
  localparam logic [31:0] FILL_LAST  = 32'(FILL_LIMIT - 1);
  localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_LIMIT - 1);
  localparam logic [31:0] WASH_LAST  = 32'(WASH_TICKS - 1);
  localparam logic [31:0] SPIN_LAST  = 32'(SPIN_TICKS - 1);
  localparam logic [3:0]  NR         = 4'(NUM_RINSE);
  logic [TIMER_W-1:0] timer;
  logic [31:0] t32;
  logic [2:0] nxt;
  logic paused, timed, fault_drained;
`ifdef WM_PAUSE_EN
  assign paused = pause && (state == S_WASH || state == S_SPIN);
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign paused = 1'b0;
`endif
  assign t32 = 32'(timer);
  assign timed = state == S_FILL || state == S_WASH || state == S_DRAIN || state == S_SPIN;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = (start && door_close) ? S_FILL : S_IDLE;
      S_FILL:  nxt = filled ? (rinse_count == 4'd0 ? S_DET : S_WASH)
                   : (tick && t32 >= FILL_LAST) ? S_FAULT : S_FILL;
      S_DET:   nxt = detergent_added ? S_WASH : S_DET;
      S_WASH:  nxt = (tick && !paused && t32 == WASH_LAST) ? S_DRAIN : S_WASH;
      S_DRAIN: nxt = drained ? (rinse_count < NR ? S_FILL : S_SPIN)
                   : (tick && t32 >= DRAIN_LAST) ? S_FAULT : S_DRAIN;
      S_SPIN:  nxt = (tick && !paused && t32 == SPIN_LAST) ? S_DONE : S_SPIN;
      S_DONE:  nxt = start ? S_DONE : S_IDLE;
      default: nxt = S_FAULT;
    endcase
    // an open door overrides every other exit
    if (!door_close && state >= S_FILL && state <= S_SPIN) nxt = S_FAULT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      timer         <= '0;
      rinse_count   <= '0;
      fault_drained <= 1'b0;
    end else begin
      state         <= nxt;
      timer         <= (nxt != state) ? '0 : (tick && timed && !paused && timer != '1) ? timer + 1'b1 : timer;
      rinse_count   <= (nxt == S_IDLE || state == S_IDLE) ? 4'd0
                     : (state == S_DRAIN && nxt == S_FILL) ? rinse_count + 4'd1 : rinse_count;
      fault_drained <= state == S_FAULT && (fault_drained || drained);
    end
  end
  assign door_lock      = (state >= S_FILL && state <= S_SPIN) || (state == S_FAULT && !fault_drained);
  assign motor_on       = (state == S_WASH || state == S_SPIN) && !paused;
  assign fill_valve_on  = state == S_FILL;
  assign drain_valve_on = state == S_DRAIN || state == S_SPIN || state == S_FAULT;
  assign soap_wash      = (state == S_DET || state == S_WASH || state == S_DRAIN) && rinse_count == 4'd0;
  assign water_wash     = (state == S_FILL || state == S_WASH || state == S_DRAIN) && rinse_count != 4'd0;
  assign done           = state == S_DONE;
  assign fault          = state == S_FAULT;
endmodule

// File: doc/wm_cycle_controller.md
Name: wm_cycle_controller

Overview:
- Parametrised washing-machine sequencer: one soap wash, NUM_RINSE rinse passes, final spin.
- Wash and spin durations timed internally from a tick strobe. No external timeout inputs.
- Fill and drain watchdogs force a latched fault state.
- Sits between the front-panel/sensor inputs and the valve/motor/lock drivers.

Parameters:
- NUM_RINSE, 1, rinse passes after the soap wash (1..15).
- TIMER_W, 16, width of the internal tick timer.
- WASH_TICKS, 1000, ticks spent agitating per wash or rinse pass (>=1, <2^TIMER_W).
- SPIN_TICKS, 500, ticks spent spinning (>=1, <2^TIMER_W).
- FILL_LIMIT, 2000, ticks allowed in FILL before fault (>=1).
- DRAIN_LIMIT, 2000, ticks allowed in DRAIN before fault (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-clock timebase strobe; all timers advance only on tick.
- start  in  1  run request (level).
- door_close  in  1  door-closed sensor.
- filled  in  1  water-level-full sensor.
- detergent_added  in  1  detergent-dispensed acknowledge.
- drained  in  1  drum-empty sensor.
- pause  in  1  pause request (used only with WM_PAUSE_EN).
- door_lock  out  1  door latch engaged.
- motor_on  out  1  drum motor drive.
- fill_valve_on  out  1  inlet valve.
- drain_valve_on  out  1  drain pump/valve.
- soap_wash  out  1  soap phase active.
- water_wash  out  1  rinse phase active.
- done  out  1  program complete.
- fault  out  1  watchdog or door fault latched.
- rinse_count  out  4  rinse passes completed.
- state  out  3  current state code for debug.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset: state=IDLE, timer=0, rinse_count=0. All outputs are 0 at reset.
- Output timing: all outputs are Moore decodes of registered state and counters. A transition takes effect one clk after its condition is sampled.
- State codes: IDLE=0, FILL=1, DETERGENT=2, WASH=3, DRAIN=4, SPIN=5, DONE=6, FAULT=7.
- Timer: cleared on every state change. Increments on tick while in FILL, WASH, DRAIN or SPIN. Saturates at all-ones.
- IDLE: all outputs 0. start & door_close -> FILL, rinse_count=0.
- FILL: door_lock=1, fill_valve_on=1.
  - filled -> DETERGENT when rinse_count==0, else WASH.
  - timer reaching FILL_LIMIT with filled low -> FAULT.
- DETERGENT: door_lock=1. detergent_added -> WASH. No timeout.
- WASH: door_lock=1, motor_on=1. tick while timer==WASH_TICKS-1 -> DRAIN (exactly WASH_TICKS ticks).
- DRAIN: door_lock=1, drain_valve_on=1.
  - drained & rinse_count<NUM_RINSE -> FILL, rinse_count+1.
  - drained & rinse_count==NUM_RINSE -> SPIN.
  - timer reaching DRAIN_LIMIT -> FAULT.
- SPIN: door_lock=1, motor_on=1, drain_valve_on=1. tick while timer==SPIN_TICKS-1 -> DONE.
- DONE: done=1, door_lock=0. start low -> IDLE. A held start does not restart the program.
- FAULT: fault=1, drain_valve_on=1, motor and fill valve off.
  - door_lock=1 until drained is seen, then door_lock=0.
  - Exit only via reset.
- soap_wash=1 in DETERGENT, WASH and DRAIN while rinse_count==0.
- water_wash=1 in FILL, WASH and DRAIN while rinse_count>0.
- Door opened: door_close low in any of FILL..SPIN -> FAULT on the next clk. This has priority over every other transition.
- Simultaneous sensor events: filled and drained are ignored outside their own states. A condition coinciding with its timeout takes the normal exit, not FAULT (except the door fault).
- start dropped mid-program: ignored; the program runs to completion.
- Reset mid-program: returns to IDLE on the next clk with every output 0.

Optional Feature:
- Macro WM_PAUSE_EN.
- Defined: pause high in WASH or SPIN forces motor_on=0 and freezes the timer; state, door_lock and rinse_count are held. Release resumes counting from the frozen value. pause in other states has no effect. Door fault still applies while paused.
- Undefined: the pause port exists but is ignored; behaviour is identical to pause=0.

Test Plan:
- Test configuration: NUM_RINSE=2, WASH_TICKS=4, SPIN_TICKS=3, FILL_LIMIT=8, DRAIN_LIMIT=8, tick=1 every clk.
- Nominal run: start=1, door_close=1, filled after 2 clk, detergent_added, drained after 2 clk in each pass -> state sequence 1,2,3,4,1,3,4,1,3,4,5,6. motor_on high exactly 4 clk per WASH and 3 clk in SPIN. rinse_count reaches 2. done=1 with door_lock=0.
- Fill watchdog: filled held 0 -> FAULT after 8 ticks, fault=1, drain_valve_on=1. drained=1 -> door_lock=0. FAULT persists until reset.
- Door open: door_close=0 on the 2nd clk of WASH -> next clk state=7, motor_on=0.
- Reset mid-SPIN: reset=1 for 1 clk -> state=0, all outputs 0, rinse_count=0. A new start runs a full program.
- DONE hold and WM_PAUSE_EN: start held high in DONE -> stays DONE. Start low -> IDLE. With WM_PAUSE_EN, pause=1 for 5 clk at timer=2 in WASH -> WASH lasts 4+5 clk and motor_on=0 during the pause.
